// File: rtl/result_serializer.sv
// Buffers up to two 32-bit result words and streams each one out MSB-first as bytes.
// Define RESULT_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte to each frame.
module result_serializer (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_bits,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [7:0]  io_out_bits,
    output logic        io_out_last,
    output logic [1:0]  io_count
);

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    logic [31:0] mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [2:0]  bidx_q, bidx_d;
    logic        push, xfer, pop;
    logic [31:0] head;

    // Ready and valid depend on the registered count only, so a pop never frees a slot in the same cycle.
    assign io_in_ready  = (count_q != 2'd2);
    assign io_out_valid = (count_q != 2'd0);
    assign io_count     = count_q;

    assign push = io_in_valid & io_in_ready;
    assign xfer = io_out_valid & io_out_ready;
    assign pop  = xfer & (bidx_q == LAST_IDX);
    assign head = mem_q[rd_ptr_q];

    assign io_out_last = io_out_valid & (bidx_q == LAST_IDX);

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        io_out_bits = 8'h00;
        case (bidx_q)
            3'd0:    io_out_bits = head[31:24];
            3'd1:    io_out_bits = head[23:16];
            3'd2:    io_out_bits = head[15:8];
            3'd3:    io_out_bits = head[7:0];
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            3'd4:    io_out_bits = head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];
`endif
            default: io_out_bits = 8'h00;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;

        bidx_d = bidx_q;
        if (pop) begin
            bidx_d = 3'd0;
        end else if (xfer) begin
            bidx_d = bidx_q + 3'd1;
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            bidx_q   <= 3'd0;
            // NOTE: the word buffer is reset too, so io_out_bits reads 0x00 while in reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bidx_q   <= bidx_d;
            if (push) begin
                mem_q[wr_ptr_q] <= io_in_bits;
            end
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: a word/byte-level model queues expected bytes,
// and a monitor compares every accepted byte and the per-cycle handshake state.
module tb_result_serializer;

`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_in_bits;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [7:0]  io_out_bits;
    logic        io_out_last;
    logic [1:0]  io_count;

    int tests = 0;
    int fails = 0;

    exp_t       exp_q[$];
    logic [7:0] obs_q[$];
    int         mdl_words = 0;
    int         head_sent = 0;

    result_serializer dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_last  (io_out_last),
        .io_count     (io_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte i of a frame: data bytes MSB-first, then (optionally) the XOR of all four.
    function automatic logic [7:0] frame_byte(input logic [31:0] w, input int i);
        logic [7:0] b;
        if (i < 4) b = w[31 - 8*i -: 8];
        else       b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        return b;
    endfunction

    // Reference model: a word is accepted when fewer than two are held; the head word
    // leaves after FRAME byte transfers.
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                mdl_words = 0;
                head_sent = 0;
                exp_q.delete();
            end else begin
                bit acc;
                bit pop;
                acc = io_in_valid && (mdl_words < 2);
                pop = 1'b0;
                if (mdl_words > 0 && io_out_ready) begin
                    if (head_sent == FRAME - 1) begin
                        pop = 1'b1;
                        head_sent = 0;
                    end else begin
                        head_sent++;
                    end
                end
                if (acc) begin
                    for (int i = 0; i < FRAME; i++) begin
                        exp_t e;
                        e.data = frame_byte(io_in_bits, i);
                        e.last = (i == FRAME - 1);
                        exp_q.push_back(e);
                    end
                end
                mdl_words = mdl_words + int'(acc) - int'(pop);
            end
        end
    end

    // Monitor: handshake state every cycle, stability under stall, and each transferred byte.
    initial begin
        bit         stall;
        logic [7:0] stall_bits;
        logic       stall_last;
        logic [3:0] exp_state;
        stall = 1'b0;
        stall_bits = 8'h00;
        stall_last = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall = 1'b0;
            end else begin
                exp_state = {2'(mdl_words), (mdl_words < 2), (mdl_words > 0)};
                check("state{count,in_ready,out_valid}",
                      {28'd0, io_count, io_in_ready, io_out_valid}, {28'd0, exp_state});
                if (stall) begin
                    check("stall_bits", {24'd0, io_out_bits}, {24'd0, stall_bits});
                    check("stall_last", {31'd0, io_out_last}, {31'd0, stall_last});
                end
                if (!io_out_valid) begin
                    check("last_when_idle", {31'd0, io_out_last}, 32'd0);
                end
                if (io_out_valid && io_out_ready) begin
                    obs_q.push_back(io_out_bits);
                    if (exp_q.size() == 0) begin
                        check("spurious_byte", {24'd0, io_out_bits}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("byte", {24'd0, io_out_bits}, {24'd0, e.data});
                        check("last", {31'd0, io_out_last}, {31'd0, e.last});
                    end
                end
                stall      = io_out_valid && !io_out_ready;
                stall_bits = io_out_bits;
                stall_last = io_out_last;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        io_in_valid = 1'b1;
        io_in_bits  = w;
        step();
        io_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        while (mdl_words != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_done", mdl_words, 0);
        step();
    endtask

    task automatic expect_obs(input string name, input logic [31:0] w0, input logic [31:0] w1,
                              input int nw);
        logic [7:0] exp_b[$];
        logic [31:0] w;
        for (int k = 0; k < nw; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int i = 0; i < FRAME; i++) exp_b.push_back(frame_byte(w, i));
        end
        check({name, "_len"}, obs_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < obs_q.size(); i++) begin
            check(name, {24'd0, obs_q[i]}, {24'd0, exp_b[i]});
        end
        obs_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, io_in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, io_out_valid}, 32'd0);
        check({tag, "_out_last"},  {31'd0, io_out_last},  32'd0);
        check({tag, "_out_bits"},  {24'd0, io_out_bits},  32'd0);
        check({tag, "_count"},     {30'd0, io_count},     32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_bits   = '0;
        io_out_ready = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Single word streamed with the consumer always ready.
        io_out_ready = 1'b1;
        push_word(32'h4080_0000);
        drain();
        expect_obs("single", 32'h4080_0000, 32'h0, 1);

        // Head byte held for three stalled cycles, then released.
        io_out_ready = 1'b0;
        push_word(32'h3F80_0000);
        step();
        step();
        step();
        drain();
        expect_obs("backpressure", 32'h3F80_0000, 32'h0, 1);

        // Third offer is refused while two words are held.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_in_bits   = 32'h4000_0000;
        step();
        io_in_bits   = 32'h4040_0000;
        step();
        io_in_bits   = 32'h4080_0000;
        step();
        io_in_valid  = 1'b0;
        check("full_count", {30'd0, io_count}, 32'd2);
        check("full_in_ready", {31'd0, io_in_ready}, 32'd0);
        drain();
        expect_obs("full_drain", 32'h4000_0000, 32'h4040_0000, 2);

        // Push lands on the same edge as the head word's final byte.
        io_out_ready = 1'b1;
        push_word(32'h4000_0000);
        for (int i = 0; i < FRAME - 1; i++) step();
        push_word(32'hC000_0000);
        check("pushpop_count", {30'd0, io_count}, 32'd1);
        drain();
        expect_obs("pushpop", 32'h4000_0000, 32'hC000_0000, 2);

        // Reset mid-frame discards the rest of the word.
        io_out_ready = 1'b1;
        push_word(32'h4080_0000);
        step();
        step();
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        step();
        reset = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 8; i++) step();
        check("midreset_no_stale", obs_q.size(), 0);
        check("midreset_idle", {31'd0, io_out_valid}, 32'd0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            io_in_valid  = ($urandom_range(0, 2) != 0);
            io_in_bits   = $urandom;
            io_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
